// File: rtl/net_egr_rate_limiter_if.sv
// -----------------------------------------------------------------------------
// net_egr_rate_limiter_if
// AXI-Stream bundle used on both sides of the egress rate limiter.
//   master : drives tdata/tid/tdest/tkeep/tlast/tvalid, receives tready
//   slave  : receives tdata/tid/tdest/tkeep/tlast/tvalid, drives tready
// tid/tdest are at least one bit wide even when their width parameter is 0.
// -----------------------------------------------------------------------------
interface net_egr_rate_limiter_if #(
    parameter int BUS_WIDTH  = 64,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4
);
    localparam int KEEP_W = BUS_WIDTH / 8;
    localparam int ID_W   = (ID_WIDTH > 0) ? ID_WIDTH : 1;
    localparam int DEST_W = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;

    logic [BUS_WIDTH-1:0] tdata;
    logic [ID_W-1:0]      tid;
    logic [DEST_W-1:0]    tdest;
    logic [KEEP_W-1:0]    tkeep;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, tid, tdest, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tid, tdest, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/net_egr_rate_limiter.sv
// -----------------------------------------------------------------------------
// net_egr_rate_limiter
// Token-bucket byte-rate limiter on the egress AXI-Stream path. Packets are
// gated only at packet boundaries; a packet admitted with a non-negative
// token count always runs to completion, driving the bucket into deficit.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   axis_in           egress stream from the protection stage (slave)
//   axis_out          rate-limited stream towards the MAC (master)
//   limiter_enable    1 = enforce, 0 = transparent bypass
//   refill_amount     bytes added per refill event
//   refill_period     cycles between refills minus one
//   bucket_size       maximum token count (burst size)
//   token_count       current signed token count
//   throttle_active   a packet head is being held for lack of tokens
// -----------------------------------------------------------------------------
module net_egr_rate_limiter #(
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 4,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int TOKEN_WIDTH     = 20,
    parameter int PERIOD_WIDTH    = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    net_egr_rate_limiter_if.slave         axis_in,
    net_egr_rate_limiter_if.master        axis_out,
    input  logic                          limiter_enable,
    input  logic [TOKEN_WIDTH-2:0]        refill_amount,
    input  logic [PERIOD_WIDTH-1:0]       refill_period,
    input  logic [TOKEN_WIDTH-2:0]        bucket_size,
    output logic signed [TOKEN_WIDTH-1:0] token_count,
    output logic                          throttle_active
);
    localparam int KEEP_W  = AXIS_BUS_WIDTH / 8;
    localparam int ID_W    = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1;
    localparam int DEST_W  = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1;
    localparam int BYTES_W = $clog2(KEEP_W + 1);
    localparam int EXT_W   = TOKEN_WIDTH + 1;
    // Most negative token value, held one bit wider for the saturation compare.
    localparam logic signed [EXT_W-1:0] TOK_MIN = {2'b11, {(TOKEN_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic [PERIOD_WIDTH-1:0]         timer_r;
    logic signed [TOKEN_WIDTH-1:0]   token_count_r;
    logic signed [TOKEN_WIDTH-1:0]   token_nxt_s;
    logic                            refill_pulse_s;
    logic                            allow_s;
    logic                            xfer_s;
    logic [BYTES_W-1:0]              bytes_s;
    logic signed [EXT_W-1:0]         tok_ext_s;
    logic signed [EXT_W-1:0]         refill_ext_s;
    logic signed [EXT_W-1:0]         bytes_ext_s;
    logic signed [EXT_W-1:0]         bucket_ext_s;
    logic signed [EXT_W-1:0]         sum_s;

    // Number of valid bytes in a beat; tkeep need not be contiguous.
    function automatic logic [BYTES_W-1:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [BYTES_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + BYTES_W'(keep[i]);
        end
        return cnt;
    endfunction

    // Zero-latency passthrough; only the handshake is gated.
    assign axis_out.tdata  = AXIS_BUS_WIDTH'(axis_in.tdata);
    assign axis_out.tid    = ID_W'(axis_in.tid);
    assign axis_out.tdest  = DEST_W'(axis_in.tdest);
    assign axis_out.tkeep  = KEEP_W'(axis_in.tkeep);
    assign axis_out.tlast  = axis_in.tlast;

    // Gate only at a packet head: once in PASS the packet flows regardless of tokens.
    assign allow_s         = !limiter_enable || (state_r == ST_PASS) || !token_count_r[TOKEN_WIDTH-1];
    assign axis_out.tvalid = axis_in.tvalid && allow_s;
    assign axis_in.tready  = axis_out.tready && allow_s;
    assign xfer_s          = axis_in.tvalid && axis_in.tready;
    assign bytes_s         = keep_popcount(axis_in.tkeep);

    assign token_count     = token_count_r;
    assign throttle_active = limiter_enable && (state_r == ST_IDLE) && axis_in.tvalid
                             && token_count_r[TOKEN_WIDTH-1];

    // '>=' rather than '==' so a period shortened below the current count still wraps.
    assign refill_pulse_s  = limiter_enable && (timer_r >= refill_period);

    // Packet boundary state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet boundary tracking; single-beat packets never leave IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && !axis_in.tlast) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (xfer_s && axis_in.tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Refill timer: counts 0..refill_period, held at zero while bypassed.
    always_ff @(posedge aclk) begin
        if (areset) begin
            timer_r <= '0;
        end else if (!limiter_enable || refill_pulse_s) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + PERIOD_WIDTH'(1);
        end
    end

    // Token arithmetic one bit wider than the counter, then saturate both ways.
    always_comb begin
        tok_ext_s    = {token_count_r[TOKEN_WIDTH-1], token_count_r};
        refill_ext_s = '0;
        bytes_ext_s  = '0;
        if (refill_pulse_s) begin
            refill_ext_s = {2'b00, refill_amount};
        end else begin
            refill_ext_s = '0;
        end
        if (xfer_s) begin
            bytes_ext_s = EXT_W'(bytes_s);
        end else begin
            bytes_ext_s = '0;
        end
        bucket_ext_s = {2'b00, bucket_size};
        sum_s        = tok_ext_s + refill_ext_s - bytes_ext_s;
        if (sum_s > bucket_ext_s) begin
            token_nxt_s = bucket_ext_s[TOKEN_WIDTH-1:0];
        end else if (sum_s < TOK_MIN) begin
            token_nxt_s = TOK_MIN[TOKEN_WIDTH-1:0];
        end else begin
            token_nxt_s = sum_s[TOKEN_WIDTH-1:0];
        end
    end

    // Token counter; bypass keeps the bucket full so enabling starts with a full burst.
    always_ff @(posedge aclk) begin
        if (areset) begin
            token_count_r <= '0;
        end else if (!limiter_enable) begin
            token_count_r <= {1'b0, bucket_size};
        end else begin
            token_count_r <= token_nxt_s;
        end
    end
endmodule

// File: tb/tb_net_egr_rate_limiter.sv
// -----------------------------------------------------------------------------
// tb_net_egr_rate_limiter
// Directed self-checking bench for the egress token-bucket rate limiter.
// Inputs are driven 1 ns after the rising edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_net_egr_rate_limiter;
    logic               aclk = 1'b0;
    logic               areset;
    logic               limiter_enable;
    logic [18:0]        refill_amount;
    logic [15:0]        refill_period;
    logic [18:0]        bucket_size;
    logic signed [19:0] token_count;
    logic               throttle_active;

    int n_checks = 0;
    int n_fail   = 0;

    net_egr_rate_limiter_if #(.BUS_WIDTH(64), .ID_WIDTH(4), .DEST_WIDTH(4)) in_if ();
    net_egr_rate_limiter_if #(.BUS_WIDTH(64), .ID_WIDTH(4), .DEST_WIDTH(4)) out_if ();

    net_egr_rate_limiter #(
        .AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(4),
        .TOKEN_WIDTH(20), .PERIOD_WIDTH(16)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .axis_in         (in_if),
        .axis_out        (out_if),
        .limiter_enable  (limiter_enable),
        .refill_amount   (refill_amount),
        .refill_period   (refill_period),
        .bucket_size     (bucket_size),
        .token_count     (token_count),
        .throttle_active (throttle_active)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] k, input logic l, input logic [63:0] d);
        in_if.tvalid = v;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        in_if.tdata  = d;
    endtask

    initial begin
        int acc;
        int gate_err;
        int beat;
        logic [15:0] pat;

        areset = 1'b1; limiter_enable = 1'b1;
        refill_amount = 19'd0; refill_period = 16'd0; bucket_size = 19'd64;
        in_if.tid = 4'd3; in_if.tdest = 4'd5;
        drive(1'b1, 8'hFF, 1'b1, 64'd0);
        out_if.tready = 1'b1;

        // ---- reset state ----
        step();
        check_eq("rst_tok", 32'(token_count), 0);
        check_eq("rst_thr", 32'(throttle_active), 0);
        check_eq("rst_ovalid", 32'(out_if.tvalid), 1);
        drive(1'b0, 8'hFF, 1'b0, 64'd0);
        step();
        areset = 1'b0;

        // ---- 1: bypass, 10 back-to-back 8-beat packets ----
        limiter_enable = 1'b0;
        acc = 0;
        for (int i = 0; i < 80; i++) begin
            drive(1'b1, 8'hFF, (i % 8) == 7, {32'hA5A5_0000, 32'(i)});
            #1;
            if (out_if.tvalid && in_if.tready) acc++;
            if (i == 37) check_eq("t1_data", int'(out_if.tdata[31:0]), 37);
            if (i == 37) check_eq("t1_tid", 32'(out_if.tid), 3);
            step();
        end
        drive(1'b0, 8'hFF, 1'b0, 64'd0);
        #1;
        check_eq("t1_beats", acc, 80);
        check_eq("t1_tok", 32'(token_count), 64);
        check_eq("t1_thr", 32'(throttle_active), 0);
        step();

        // ---- 2: bucket 64, refill 8 every 8 cycles, 16-beat packet then held head ----
        refill_amount = 19'd8; refill_period = 16'd7; bucket_size = 19'd64;
        acc = 0;
        for (int k = 0; k <= 65; k++) begin
            limiter_enable = 1'b1;
            if (k == 0)       drive(1'b0, 8'hFF, 1'b0, 64'd0);
            else if (k <= 16) drive(1'b1, 8'hFF, k == 16, 64'(k));
            else if (k <= 64) drive(1'b1, 8'hFF, 1'b1, 64'd100);
            else              drive(1'b0, 8'hFF, 1'b0, 64'd0);
            #1;
            if (k >= 1 && k <= 16 && out_if.tvalid && in_if.tready) acc++;
            if (k == 17) begin
                check_eq("t2_tok_after", 32'(token_count), -48);
                check_eq("t2_thr_on", 32'(throttle_active), 1);
                check_eq("t2_rdy_held", 32'(in_if.tready), 0);
                check_eq("t2_ovalid_held", 32'(out_if.tvalid), 0);
            end
            if (k == 63) begin
                check_eq("t2_tok_63", 32'(token_count), -8);
                check_eq("t2_thr_63", 32'(throttle_active), 1);
            end
            if (k == 64) begin
                check_eq("t2_tok_64", 32'(token_count), 0);
                check_eq("t2_thr_64", 32'(throttle_active), 0);
                check_eq("t2_rdy_64", 32'(in_if.tready), 1);
            end
            if (k == 65) check_eq("t2_tok_65", 32'(token_count), -8);
            step();
        end
        check_eq("t2_beats", acc, 16);

        // ---- 3: tokens 0, no refill, 4-byte single beat then held forever ----
        limiter_enable = 1'b0; bucket_size = 19'd0;
        step();
        limiter_enable = 1'b1; bucket_size = 19'd64; refill_amount = 19'd0;
        drive(1'b1, 8'h0F, 1'b1, 64'd7);
        #1;
        check_eq("t3_tok0", 32'(token_count), 0);
        check_eq("t3_rdy0", 32'(in_if.tready), 1);
        step();
        drive(1'b1, 8'hFF, 1'b1, 64'd8);
        #1;
        check_eq("t3_tok_neg", 32'(token_count), -4);
        check_eq("t3_thr", 32'(throttle_active), 1);
        for (int i = 0; i < 20; i++) step();
        check_eq("t3_tok_hold", 32'(token_count), -4);
        check_eq("t3_rdy_hold", 32'(in_if.tready), 0);
        drive(1'b0, 8'hFF, 1'b0, 64'd0);

        // ---- 4: refill and consume in the same cycle; bucket clamp ----
        limiter_enable = 1'b0; bucket_size = 19'd10;
        step();
        limiter_enable = 1'b1; bucket_size = 19'd64;
        refill_amount = 19'd8; refill_period = 16'd0;
        drive(1'b1, 8'hFF, 1'b1, 64'd9);
        #1;
        check_eq("t4_tok_pre", 32'(token_count), 10);
        step();
        drive(1'b0, 8'hFF, 1'b0, 64'd0);
        #1;
        check_eq("t4_same_cycle", 32'(token_count), 10);
        step();
        check_eq("t4_refill", 32'(token_count), 18);
        bucket_size = 19'd12;
        step();
        check_eq("t4_clamp", 32'(token_count), 12);

        // ---- 5: tready toggling mid-packet while tokens go negative ----
        limiter_enable = 1'b0; bucket_size = 19'd16;
        step();
        limiter_enable = 1'b1; refill_amount = 19'd0;
        pat = 16'b1011_0011_0101_1001;
        beat = 0; gate_err = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            out_if.tready = pat[c % 16];
            drive(1'b1, 8'hFF, beat == 7, 64'(beat));
            #1;
            if (!out_if.tvalid) gate_err++;
            if (out_if.tvalid && out_if.tready) begin
                check_eq("t5_data", int'(out_if.tdata[31:0]), beat);
                beat++;
            end
            step();
        end
        out_if.tready = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 64'd50);
        #1;
        check_eq("t5_beats", beat, 8);
        check_eq("t5_no_gate", gate_err, 0);
        check_eq("t5_tok", 32'(token_count), -48);
        check_eq("t5_thr_next", 32'(throttle_active), 1);
        step();

        // ---- 6: enable rising mid-packet, then reset mid-packet ----
        limiter_enable = 1'b0; bucket_size = 19'd16;
        drive(1'b1, 8'hFF, 1'b0, 64'd60);
        step();
        limiter_enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #1;
        check_eq("t6_tok_deficit", 32'(token_count), -8);
        check_eq("t6_midpkt_pass", 32'(out_if.tvalid), 1);
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 64'd61);
        #1;
        check_eq("t6_rst_tok", 32'(token_count), 0);
        check_eq("t6_rst_thr", 32'(throttle_active), 0);
        step();
        #1;
        check_eq("t6_idle_tok", 32'(token_count), -8);
        check_eq("t6_idle_thr", 32'(throttle_active), 1);
        check_eq("t6_idle_gate", 32'(out_if.tvalid), 0);
        drive(1'b0, 8'hFF, 1'b0, 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
